// File: rtl/stream_feeder_pkg.sv
// Shared types and constants for the stream feeder.
// STREAM_FEEDER_SEQ_END_EN adds the ENDCODE state that appends a sequence-end code.
package stream_feeder_pkg;

  localparam int unsigned DefaultFifoDepth = 16;

  // Index 0 is sent first: 00 00 01 B7.
  localparam logic [3:0][7:0] SeqEndCode = {8'hB7, 8'h01, 8'h00, 8'h00};

  typedef enum logic [2:0] {
    StIdle,
    StFeed,
    StDrain,
`ifdef STREAM_FEEDER_SEQ_END_EN
    StEndcode,
`endif
    StDone
  } state_e;

endpackage

// File: rtl/stream_feeder_if.sv
// Host-side byte input and decoder-side byte output of the stream feeder.
interface stream_feeder_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] stream_data;
  logic       stream_valid;
  logic       busy;

  modport master (
    input  in_data, in_valid, busy,
    output in_ready, stream_data, stream_valid
  );

  modport slave (
    output in_data, in_valid, busy,
    input  in_ready, stream_data, stream_valid
  );
endinterface

// File: rtl/feeder_fifo.sv
// Synchronous byte FIFO with registered occupancy count and full/empty flags.
module feeder_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  assign rdata = mem[rptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  always_ff @(posedge sys_clk) begin
    if (push) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/stream_feeder.sv
// Buffers elementary-stream bytes and feeds them to the decoder under play/busy control.
// STREAM_FEEDER_SEQ_END_EN appends 00 00 01 B7 after a flushed stream drains.
module stream_feeder
  import stream_feeder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefaultFifoDepth,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               play,
  input  logic               flush,
  stream_feeder_if.master    bus,
  output logic [COUNT_W-1:0] stream_dat_count,
  output logic               done
);
  state_e state_q, state_d;

  logic       rdy_en_q;
  logic       fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_src;
  logic [7:0] fifo_rdata;
  // One-byte stage between FIFO and output register; gives the two-edge latency.
  logic [7:0] hold_q;
  logic       hold_valid_q;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic [COUNT_W-1:0] count_q;
  logic       src_avail, emit;
  logic [7:0] src_byte;
`ifdef STREAM_FEEDER_SEQ_END_EN
  logic [1:0] end_idx_q;
`endif

  feeder_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst     (rst),
    .push    (fifo_push),
    .wdata   (bus.in_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.in_ready     = rdy_en_q && !fifo_full && (state_q == StIdle || state_q == StFeed);
  assign bus.stream_valid = out_valid_q;
  assign bus.stream_data  = out_data_q;
  assign stream_dat_count = count_q;
  assign done             = (state_q == StDone);
  assign fifo_push        = bus.in_valid && bus.in_ready;
  assign fifo_src         = (state_q == StFeed) || (state_q == StDrain);

  always_comb begin
    src_avail = fifo_src && hold_valid_q;
    src_byte  = hold_q;
`ifdef STREAM_FEEDER_SEQ_END_EN
    if (state_q == StEndcode) begin
      src_avail = 1'b1;
      src_byte  = SeqEndCode[end_idx_q];
    end
`endif
    emit     = src_avail && play && !bus.busy;
    fifo_pop = fifo_src && play && !fifo_empty && (!hold_valid_q || emit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (play) state_d = StFeed;
      StFeed: begin
        if (flush)      state_d = StDrain;
        else if (!play) state_d = StIdle;
      end
      StDrain: begin
        if (fifo_empty && !hold_valid_q) begin
`ifdef STREAM_FEEDER_SEQ_END_EN
          state_d = StEndcode;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef STREAM_FEEDER_SEQ_END_EN
      StEndcode: if (emit && end_idx_q == 2'd3) state_d = StDone;
`endif
      StDone:  if (!play) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rdy_en_q     <= 1'b0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      count_q      <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      out_valid_q <= emit;
      if (fifo_pop) begin
        hold_q       <= fifo_rdata;
        hold_valid_q <= 1'b1;
      end else if (emit) begin
        hold_valid_q <= 1'b0;
      end
      if (emit) begin
        out_data_q <= src_byte;
        count_q    <= count_q + COUNT_W'(1);
      end
    end
  end

`ifdef STREAM_FEEDER_SEQ_END_EN
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                        end_idx_q <= '0;
    else if (state_q != StEndcode)  end_idx_q <= '0;
    else if (emit)                  end_idx_q <= end_idx_q + 2'd1;
  end
`endif
endmodule

// File: tb/tb_stream_feeder.sv
// Directed bench for stream_feeder with a queue-based model of the byte stream.
module tb_stream_feeder;
`ifdef STREAM_FEEDER_SEQ_END_EN
  localparam bit EndEn = 1'b1;
`else
  localparam bit EndEn = 1'b0;
`endif
  localparam int unsigned FlushAdd = EndEn ? 7 : 3;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] stream_dat_count;
  logic        done;
  logic [1:0]  count_n;
  logic        done_n;

  stream_feeder_if bus ();
  stream_feeder_if bus_n ();

  // Narrow-counter twin sees identical stimulus; its count shows the wrap.
  assign bus_n.in_data  = bus.in_data;
  assign bus_n.in_valid = bus.in_valid;
  assign bus_n.busy     = bus.busy;

  stream_feeder #(.FIFO_DEPTH(16), .COUNT_W(32)) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .play             (play),
    .flush            (flush),
    .bus              (bus),
    .stream_dat_count (stream_dat_count),
    .done             (done)
  );

  stream_feeder #(.FIFO_DEPTH(16), .COUNT_W(2)) dut_n (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .play             (play),
    .flush            (flush),
    .bus              (bus_n),
    .stream_dat_count (count_n),
    .done             (done_n)
  );

  always #5 sys_clk = ~sys_clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] count_m = '0;
  int          n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Model: accepted bytes (plus end code on flush) must come out in order, one per valid.
  always @(posedge sys_clk) begin
    logic       play_s, busy_s, acc, flush_s;
    logic [7:0] din;
    play_s  = play;
    busy_s  = bus.busy;
    acc     = bus.in_valid && bus.in_ready;
    din     = bus.in_data;
    flush_s = flush;
    #1;
    if (rst) begin
      exp_q.delete();
      count_m = '0;
    end else begin
      if (acc) exp_q.push_back(din);
      if (flush_s && EndEn) begin
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hB7);
      end
      if (bus.stream_valid) begin
        n_out++;
        count_m = count_m + 32'd1;
        chk("valid_gate", {30'd0, play_s, busy_s}, 32'd2);
        if (exp_q.size() == 0) chk("spurious_byte", 32'd1, 32'd0);
        else chk("byte", {24'd0, bus.stream_data}, {24'd0, exp_q.pop_front()});
      end
      chk("count", stream_dat_count, count_m);
      chk("count_narrow", {30'd0, count_n}, {30'd0, count_m[1:0]});
    end
  end

  task automatic push_seq(input logic [7:0] first, input int n, output int acc_n);
    acc_n = 0;
    for (int c = 0; c < n + 16 && acc_n < n; c++) begin
      logic go;
      bus.in_data  = first + 8'(acc_n);
      bus.in_valid = 1'b1;
      go = bus.in_ready;
      @(negedge sys_clk);
      if (go) acc_n++;
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc, cnt0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.busy     = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_valid", {31'd0, bus.stream_valid}, 32'd0);
    chk("rst_data", {24'd0, bus.stream_data}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", stream_dat_count, 32'd0);
    rst = 1'b0;
    #1 chk("ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
    @(negedge sys_clk);
    chk("ready_first_edge", {31'd0, bus.in_ready}, 32'd1);

    // Four bytes, latency from first push
    play = 1'b1;
    @(negedge sys_clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    @(negedge sys_clk);
    chk("lat_n", {31'd0, bus.stream_valid}, 32'd0);
    bus.in_data = 8'h00;
    @(negedge sys_clk);
    chk("lat_n1", {31'd0, bus.stream_valid}, 32'd0);
    bus.in_data = 8'h01;
    @(negedge sys_clk);
    chk("lat_n2", {31'd0, bus.stream_valid}, 32'd1);
    chk("lat_byte", {24'd0, bus.stream_data}, 32'd0);
    bus.in_data = 8'hB3;
    @(negedge sys_clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("t1_count", stream_dat_count, 32'd4);
    chk("t1_count_wrap", {30'd0, count_n}, 32'd0);
    chk("t1_drained", exp_q.size(), 32'd0);

    // Fill while paused, then release
    play = 1'b0;
    @(negedge sys_clk);
    base = n_out;
    push_seq(8'h10, 20, acc);
    chk("t2_accepted", acc, 32'd16);
    chk("t2_full_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t2_no_out", n_out - base, 32'd0);
    play = 1'b1;
    repeat (25) @(negedge sys_clk);
    chk("t2_out16", n_out - base, 32'd16);
    push_seq(8'h20, 4, acc);
    chk("t2_rest_accepted", acc, 32'd4);
    repeat (6) @(negedge sys_clk);
    chk("t2_out20", n_out - base, 32'd20);
    chk("t2_drained", exp_q.size(), 32'd0);

    // Back-pressure mid-stream
    play = 1'b0;
    @(negedge sys_clk);
    base = n_out;
    push_seq(8'h40, 12, acc);
    play = 1'b1;
    repeat (4) @(negedge sys_clk);
    bus.busy = 1'b1;
    cnt0 = n_out;
    repeat (10) @(negedge sys_clk);
    chk("t3_busy_hold", n_out - cnt0, 32'd0);
    bus.busy = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("t3_total", n_out - base, 32'd12);
    chk("t3_drained", exp_q.size(), 32'd0);

    // Flush with three bytes queued
    bus.busy = 1'b1;
    push_seq(8'h60, 3, acc);
    cnt0 = count_m;
    flush = 1'b1;
    @(negedge sys_clk);
    flush = 1'b0;
    bus.busy = 1'b0;
    for (int c = 0; c < 40 && !done; c++) @(negedge sys_clk);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_ready_in_done", {31'd0, bus.in_ready}, 32'd0);
    repeat (2) @(negedge sys_clk);
    chk("t4_count_delta", stream_dat_count - cnt0, FlushAdd);
    chk("t4_drained", exp_q.size(), 32'd0);
    play = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("t4_done_clear", {31'd0, done}, 32'd0);

    // Asynchronous reset while streaming
    play = 1'b1;
    bus.busy = 1'b1;
    @(negedge sys_clk);
    push_seq(8'h80, 5, acc);
    bus.busy = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", {31'd0, bus.stream_valid}, 32'd0);
    chk("t5_data", {24'd0, bus.stream_data}, 32'd0);
    chk("t5_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("t5_count", stream_dat_count, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    base = n_out;
    repeat (12) @(negedge sys_clk);
    chk("t5_quiet", n_out - base, 32'd0);
    push_seq(8'h9A, 1, acc);
    repeat (4) @(negedge sys_clk);
    chk("t5_new_byte", n_out - base, 32'd1);
    chk("t5_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
